// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and serialises it as 8N1/8N2,
// LSB first, with bit timing derived from the system clock.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next, done_next;
    logic             bit_end;

    // Handshake: a byte moves on a rising edge where ready && data_valid; data_valid while busy is dropped.
    assign ready   = (state == IDLE);
    assign busy    = ~ready;
    assign bit_end = (clk_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            done    <= done_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state;
        tx_next      = tx;
        done_next    = 1'b0;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        case (state)
            IDLE: begin
                tx_next      = 1'b1;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (data_valid) begin
                    shift_next = data_in;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    clk_cnt_next = '0;
                    tx_next      = shift[0];
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    // tx is registered, so it is loaded with the bit that becomes current next cycle
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = shift[1];
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    clk_cnt_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit, one instance with one stop bit
// and one with two stop bits.
module tb_uart_tx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       dv1, dv2;
    logic       ready1, tx1, busy1, done1;
    logic       ready2, tx2, busy2, done2;
    int         n_cmp = 0;
    int         n_mis = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv2),
        .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input int stops, input logic v);
        if (stops == 2) dv2 = v;
        else dv1 = v;
    endtask

    // Call at a negedge with the byte already presented; the next posedge must accept it.
    // exp_bits[i] is the hand-computed line level of frame bit i (start, d0..d7, stop, stop).
    task automatic frame_check(input string name, input logic [10:0] exp_bits, input int stops,
                               input bit drop_valid, input logic [7:0] next_data, input int poke_k);
        int   last, n_done, n_nbusy, n_stop_lo;
        logic t, r, b, d;
        last      = (9 + stops) * CPB;
        n_done    = 0;
        n_nbusy   = 0;
        n_stop_lo = 0;
        @(posedge clk);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            t = (stops == 2) ? tx2    : tx1;
            r = (stops == 2) ? ready2 : ready1;
            b = (stops == 2) ? busy2  : busy1;
            d = (stops == 2) ? done2  : done1;
            if (k == 0) begin
                check($sformatf("%s/start_latency", name), 32'(t), 32'd0);
                data_in = next_data;
                if (drop_valid) set_valid(stops, 1'b0);
            end
            if (k == poke_k) begin
                data_in = 8'hFF;
                set_valid(stops, 1'b1);
            end
            if (poke_k >= 0 && k == poke_k + 1) begin
                set_valid(stops, 1'b0);
                data_in = 8'hAA;
            end
            if (k < last) begin
                if (d) n_done++;
                if (r || !b) n_nbusy++;
                if (k >= 9 * CPB && !t) n_stop_lo++;
                if (k % CPB == CPB / 2)
                    check($sformatf("%s/bit%0d", name, k / CPB), 32'(t), 32'(exp_bits[k / CPB]));
            end else begin
                check($sformatf("%s/done_at_end", name), 32'(d), 32'd1);
                check($sformatf("%s/ready_at_end", name), 32'(r), 32'd1);
                check($sformatf("%s/idle_gap_high", name), 32'(t), 32'd1);
            end
        end
        check($sformatf("%s/early_done", name), 32'(n_done), 32'd0);
        check($sformatf("%s/not_busy_in_frame", name), 32'(n_nbusy), 32'd0);
        check($sformatf("%s/stop_low_cycles", name), 32'(n_stop_lo), 32'd0);
    endtask

    initial begin
        int bad;
        rst     = 1'b0;
        dv1     = 1'b0;
        dv2     = 1'b0;
        data_in = 8'h5A;

        // Held in reset while data_valid toggles.
        @(negedge clk);
        check("rst/tx1", 32'(tx1), 32'd1);
        check("rst/ready1", 32'(ready1), 32'd1);
        check("rst/busy1", 32'(busy1), 32'd0);
        check("rst/done1", 32'(done1), 32'd0);
        check("rst/tx2", 32'(tx2), 32'd1);
        check("rst/ready2", 32'(ready2), 32'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            dv1     = ~dv1;
            dv2     = ~dv2;
            data_in = 8'(i * 37);
            @(negedge clk);
            if (!tx1 || !ready1 || busy1 || done1 || !tx2 || !ready2 || busy2 || done2) bad++;
        end
        check("rst/hold_toggle", 32'(bad), 32'd0);
        dv1 = 1'b0;
        dv2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // 0x55: alternating line, done 160 cycles after accept.
        data_in = 8'h55;
        dv1     = 1'b1;
        frame_check("x55", 11'b11_01010101_0, 1, 1'b1, 8'h00, -1);

        // 0xA5 then 0x3C back-to-back with valid held high; data_in changes mid-frame.
        data_in = 8'hA5;
        dv1     = 1'b1;
        frame_check("xA5", 11'b11_10100101_0, 1, 1'b0, 8'h3C, -1);
        frame_check("x3C", 11'b11_00111100_0, 1, 1'b1, 8'h00, -1);

        // 0x0F with a 0xFF valid pulse in the middle of data bit 2.
        data_in = 8'h0F;
        dv1     = 1'b1;
        frame_check("x0F", 11'b11_00001111_0, 1, 1'b1, 8'h00, 50);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx1 || !ready1 || busy1 || done1) bad++;
        end
        check("x0F/no_second_frame", 32'(bad), 32'd0);

        // 0xC3 abandoned by reset during data bit 3.
        data_in = 8'hC3;
        dv1     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0;
        repeat (70) @(negedge clk);
        check("xC3/bit3_before_rst", 32'(tx1), 32'd0);
        rst = 1'b0;
        #1;
        check("xC3/rst_tx", 32'(tx1), 32'd1);
        check("xC3/rst_ready", 32'(ready1), 32'd1);
        check("xC3/rst_busy", 32'(busy1), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done1 || !tx1) bad++;
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1 || !tx1 || !ready1) bad++;
        end
        check("xC3/no_done_after_rst", 32'(bad), 32'd0);
        data_in = 8'h00;
        dv1     = 1'b1;
        frame_check("x00", 11'b11_00000000_0, 1, 1'b1, 8'h00, -1);

        // Two stop bits: 0x80, stop high 32 cycles, done 176 cycles after accept.
        data_in = 8'h80;
        dv2     = 1'b1;
        frame_check("x80_2stop", 11'b11_10000000_0, 2, 1'b1, 8'h00, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
